// File: rtl/interface_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 interface: state encodings, parameter
// defaults, the timeout error code and the saturating BCD increment.
package interface_hcsr04_pkg;

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      PREPARACAO    = 4'd1,
      ENVIA_TRIGGER = 4'd2,
      ESPERA_ECHO   = 4'd3,
      MEDE          = 4'd4,
      ARMAZENA      = 4'd5,
      FINAL_MEDIDA  = 4'd6
   } estado_t;

   localparam int TRIG_CYCLES_DEF    = 500;
   localparam int CM_CYCLES_DEF      = 2941;
   localparam int TIMEOUT_CYCLES_DEF = 1250000;

   localparam logic [11:0] MEDIDA_ERRO     = 12'hFFF;
   localparam logic [11:0] BCD_MAX         = 12'h999;
   localparam logic [3:0]  ESTADO_INVALIDO = 4'hF;

   // Three-digit BCD increment that sticks at 999 instead of wrapping.
   function automatic logic [11:0] bcd_incr_sat(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v == BCD_MAX) begin
         r = v;
      end else if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd9) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4]  = 4'd0;
            r[11:8] = v[11:8] + 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/interface_hcsr04_contador_cm.sv
// contador_cm: modulo-CM_CYCLES tick counter feeding a 3-digit BCD counter
// that saturates at 999 centimetres.
module contador_cm
   import interface_hcsr04_pkg::*;
#(
   parameter int CM_CYCLES = CM_CYCLES_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        zera,
   input  logic        conta,
   output logic [11:0] bcd
);

   localparam int TW = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;

   logic [TW-1:0] tick_r;
   logic [11:0]   bcd_r;

   // Tick counter wraps once per centimetre of echo and bumps the BCD count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_r <= '0;
         bcd_r  <= 12'h000;
      end else if (zera) begin
         tick_r <= '0;
         bcd_r  <= 12'h000;
      end else if (conta) begin
         if (tick_r == TW'(CM_CYCLES - 1)) begin
            tick_r <= '0;
            bcd_r  <= bcd_incr_sat(bcd_r);
         end else begin
            tick_r <= tick_r + {{(TW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bcd = bcd_r;

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 driver: trigger pulse, echo timing and BCD centimetre result.
// Optional echo watchdog enabled by defining HCSR04_TIMEOUT_EN.
module interface_hcsr04
   import interface_hcsr04_pkg::*;
#(
   parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
   parameter int CM_CYCLES      = CM_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inicia,
   input  logic        echo,
   output logic        trigger,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado
);

   localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);

   estado_t           estado, estado_prox;
   logic              echo_meta, echo_s;
   logic [TRIG_W-1:0] trig_cnt;
   logic              trig_fim;
   logic              timeout_s;
   logic [3:0]        db_estado_s;
   logic              trigger_r, pronto_r;
   logic [11:0]       medida_r;
   logic [11:0]       bcd;

   // Two-flop synchronizer for the asynchronous echo line.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         echo_meta <= 1'b0;
         echo_s    <= 1'b0;
      end else begin
         echo_meta <= echo;
         echo_s    <= echo_meta;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estado <= INICIAL;
      else        estado <= estado_prox;
   end

   // Trigger-width counter, restarted for every measurement.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trig_cnt <= '0;
      end else if (estado == PREPARACAO) begin
         trig_cnt <= '0;
      end else if (estado == ENVIA_TRIGGER) begin
         trig_cnt <= trig_cnt + {{(TRIG_W-1){1'b0}}, 1'b1};
      end
   end

   assign trig_fim = (trig_cnt == TRIG_W'(TRIG_CYCLES - 1));

`ifdef HCSR04_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            erro_r;
   logic            wd_ativo;

   assign wd_ativo  = (estado == ESPERA_ECHO) || (estado == MEDE);
   assign timeout_s = wd_ativo && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog runs only while waiting for or timing the echo.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        wd_cnt <= '0;
      else if (wd_ativo) wd_cnt <= wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};
      else               wd_cnt <= '0;
   end

   // Error flag survives until the next measurement starts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                     erro_r <= 1'b0;
      else if (estado == PREPARACAO)  erro_r <= 1'b0;
      else if (timeout_s)             erro_r <= 1'b1;
   end

   assign erro = erro_r;
`else
   assign timeout_s = 1'b0;
   assign erro      = 1'b0;
`endif

   // Next-state logic; illegal encodings recover to idle and flag 4'hF.
   always_comb begin
      estado_prox = estado;
      db_estado_s = estado;
      case (estado)
         INICIAL: begin
            if (inicia) estado_prox = PREPARACAO;
            else        estado_prox = INICIAL;
         end
         PREPARACAO:    estado_prox = ENVIA_TRIGGER;
         ENVIA_TRIGGER: begin
            if (trig_fim) estado_prox = ESPERA_ECHO;
            else          estado_prox = ENVIA_TRIGGER;
         end
         ESPERA_ECHO: begin
            if (timeout_s)   estado_prox = FINAL_MEDIDA;
            else if (echo_s) estado_prox = MEDE;
            else             estado_prox = ESPERA_ECHO;
         end
         MEDE: begin
            if (timeout_s)    estado_prox = FINAL_MEDIDA;
            else if (!echo_s) estado_prox = ARMAZENA;
            else              estado_prox = MEDE;
         end
         ARMAZENA:      estado_prox = FINAL_MEDIDA;
         FINAL_MEDIDA:  estado_prox = INICIAL;
         default: begin
            estado_prox = INICIAL;
            db_estado_s = ESTADO_INVALIDO;
         end
      endcase
   end

   // Registered outputs decoded from the upcoming state so they align with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trigger_r <= 1'b0;
         pronto_r  <= 1'b0;
         medida_r  <= 12'h000;
      end else begin
         trigger_r <= (estado_prox == ENVIA_TRIGGER);
         pronto_r  <= (estado_prox == FINAL_MEDIDA);
         if (estado == ARMAZENA) medida_r <= bcd;
         else if (timeout_s)     medida_r <= MEDIDA_ERRO;
      end
   end

   contador_cm #(
      .CM_CYCLES (CM_CYCLES)
   ) u_contador_cm (
      .clock (clock),
      .reset (reset),
      .zera  (estado == PREPARACAO),
      .conta (estado == MEDE),
      .bcd   (bcd)
   );

   assign trigger   = trigger_r;
   assign pronto    = pronto_r;
   assign medida    = medida_r;
   assign db_estado = db_estado_s;

endmodule

// File: tb/tb_interface_hcsr04.sv
// Scoreboard bench for interface_hcsr04 with small parameters; the timeout
// scenario follows HCSR04_TIMEOUT_EN when it is defined.
module tb_interface_hcsr04;

   localparam int TRIG = 5;
   localparam int CM   = 10;
   localparam int TOUT = 200;

   logic        clock = 1'b0;
   logic        reset;
   logic        inicia;
   logic        echo;
   logic        trigger;
   logic [11:0] medida;
   logic        pronto;
   logic        erro;
   logic [3:0]  db_estado;

   logic [12:0] exp_q[$];
   int n_chk    = 0;
   int n_pass   = 0;
   int n_pronto = 0;
   int trig_run = 0;
   logic prev_pronto = 1'b0;

   interface_hcsr04 #(
      .TRIG_CYCLES    (TRIG),
      .CM_CYCLES      (CM),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .inicia    (inicia),
      .echo      (echo),
      .trigger   (trigger),
      .medida    (medida),
      .pronto    (pronto),
      .erro      (erro),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s bound expired", name);
   endtask

   // Reference: whole centimetres, clamped at 999, as three BCD digits.
   function automatic logic [11:0] bcd_of(input int n);
      int v;
      v = n / CM;
      if (v > 999) v = 999;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: trigger width, single-cycle pronto, scoreboard pop on pronto.
   always @(negedge clock) begin
      logic [12:0] e;
      if (!reset) begin
         trig_run    = 0;
         prev_pronto = 1'b0;
      end else begin
         if (trigger) trig_run++;
         else if (trig_run != 0) begin
            check("trigger_width", trig_run, TRIG);
            trig_run = 0;
         end
         if (pronto) begin
            n_pronto++;
            check("pronto_single", int'(prev_pronto), 0);
            if (exp_q.size() == 0) fail_now("pronto_unexpected");
            else begin
               e = exp_q.pop_front();
               check("medida", int'(medida), int'(e[11:0]));
               check("erro", int'(erro), int'(e[12]));
            end
         end
         prev_pronto = pronto;
      end
   end

   task automatic start_pulse();
      inicia = 1'b1;
      tick(1);
      inicia = 1'b0;
   endtask

   task automatic measure(input int n, input bit poke);
      int t, target;
      exp_q.push_back({1'b0, bcd_of(n)});
      target = n_pronto + 1;
      start_pulse();
      t = 0;
      while (!trigger && t < 50) begin tick(1); t++; end
      while (trigger && t < 50) begin tick(1); t++; end
      if (t >= 50) fail_now("trigger_wait");
      tick($urandom_range(0, 3));
      echo = 1'b1;
      for (int i = 0; i < n; i++) begin
         inicia = poke && (i == n / 2);
         tick(1);
      end
      inicia = 1'b0;
      echo   = 1'b0;
      t = 0;
      while (n_pronto < target && t < 50) begin tick(1); t++; end
      if (n_pronto < target) fail_now("pronto_wait");
      tick(2);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_trigger"}, int'(trigger), 0);
      check({tag, "_pronto"}, int'(pronto), 0);
      check({tag, "_erro"}, int'(erro), 0);
      check({tag, "_medida"}, int'(medida), 0);
      check({tag, "_estado"}, int'(db_estado), 0);
   endtask

   initial begin
      int t, base;
      reset  = 1'b0;
      inicia = 1'b0;
      echo   = 1'b0;
      tick(3);
      check_reset_values("rst");
      reset = 1'b1;
      tick(2);

      measure(123, 1'b0);
      measure(10050, 1'b0);
      measure(60, 1'b1);
      tick(3);
      check("idle_after_busy", int'(db_estado), 0);

      // Reset in the middle of the trigger pulse.
      start_pulse();
      t = 0;
      while (!trigger && t < 20) begin tick(1); t++; end
      if (!trigger) fail_now("trigger_rise");
      tick(2);
      reset = 1'b0;
      #1;
      check_reset_values("midrst");
      tick(2);
      reset = 1'b1;
      tick(3);
      check("estado_after_rst", int'(db_estado), 0);

      measure(47, 1'b0);
      measure(20, 1'b0);
      for (int k = 0; k < 6; k++) begin
         measure(int'($urandom_range(1, 400)), 1'(($urandom_range(0, 1))));
      end

`ifdef HCSR04_TIMEOUT_EN
      exp_q.push_back({1'b1, 12'hFFF});
      base = n_pronto;
      start_pulse();
      t = 0;
      while (n_pronto == base && t < 400) begin tick(1); t++; end
      if (n_pronto == base) fail_now("timeout_pronto");
      tick(2);
      check("erro_held", int'(erro), 1);
      measure(35, 1'b0);
`else
      base = n_pronto;
      start_pulse();
      tick(300);
      check("stall_estado", int'(db_estado), 3);
      check("stall_no_pronto", n_pronto, base);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(2);
      measure(35, 1'b0);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
